uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Asynchronous serial receiver: 8N1 by default, LSB first, idle-high line.
- Consumes an oversampling tick from a baud_rate_generator instance configured at BAUD_RATE × OVERSAMPLE.
- Recovers each frame by mid-bit sampling and presents the byte with a one-cycle valid strobe.
- Sits between the external rx pin and the case-converter datapath; reports framing errors.

Parameters:
- DATA_BITS, 8, data bits per frame (5..8).
- OVERSAMPLE, 16, sample_tick pulses per bit period (even, ≥4).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- sample_tick  input  1  one-cycle pulse at OVERSAMPLE × baud rate.
- rx  input  1  asynchronous serial line, idle high.
- rx_data  output  DATA_BITS  last correctly received byte.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- frame_err  output  1  one-cycle pulse when the stop bit samples 0.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Interface (already decided): one clock, clk. Reset rst_n is synchronous and active-low, sampled on the rising edge of clk only.
- Reset values: rx_data=0, rx_valid=0, frame_err=0, busy=0, state=IDLE, sync flops=1, counters=0, shift register=0.
- rx passes through a 2-flop synchronizer (rx_sync). All decisions use rx_sync, and only on cycles where sample_tick=1. Non-tick cycles hold all state except single-cycle strobes, which clear.
- tick_cnt is $clog2(OVERSAMPLE) bits wide. bit_idx is $clog2(DATA_BITS) bits wide, minimum 1.
- States:
  - IDLE: on tick with rx_sync=0 → START, tick_cnt=0.
  - START: on tick, if tick_cnt==OVERSAMPLE/2-1:
    - rx_sync=0 → DATA, tick_cnt=0, bit_idx=0.
    - rx_sync=1 → IDLE (glitch rejected; no strobe).
    - Otherwise tick_cnt++.
  - DATA: on tick, if tick_cnt==OVERSAMPLE-1:
    - Shift right with rx_sync entering at the MSB; tick_cnt=0.
    - If bit_idx==DATA_BITS-1 → STOP, else bit_idx++.
    - Otherwise tick_cnt++.
  - STOP: on tick, if tick_cnt==OVERSAMPLE-1:
    - rx_sync=1 → rx_data<=shift register, rx_valid=1 for one cycle, → IDLE.
    - rx_sync=0 → frame_err=1 for one cycle, rx_data unchanged, → BREAK.
  - BREAK: on tick with rx_sync=1 → IDLE. Stuck-low line or break produces exactly one frame_err, not repeated frames.
- Sampling lands at mid-bit for start, data and stop bits.
- Return to IDLE occurs at mid-stop bit, so a following start bit is detected with no lost frame.
- Latency: rx_valid asserts on the clk edge that processes the mid-stop-bit tick. rx_valid and frame_err are never high together.
- Rx edge to rx_sync: 2 clk cycles.
- rx_data holds its value until the next valid frame. No backpressure: the consumer must take rx_data within one frame time.
- Reset asserted mid-frame: all state returns to reset values on that edge. The partial frame is discarded with no strobe.
- sample_tick held high continuously is legal. Each clk then counts as one tick.

Test Plan:
(Bench defaults: OVERSAMPLE=16, sample_tick every 4 clk, bit period 64 clk.)
1. Send frame 0x61 ('a'): start, bits 1,0,0,0,0,1,1,0, stop → rx_data=0x61 with a single-cycle rx_valid about 9.5 bit periods after the start edge; busy high throughout, low after; frame_err stays 0.
2. Back-to-back frames 0x00 then 0xFF with no idle gap → two rx_valid pulses, rx_data=0x00 then 0xFF, no frame_err.
3. rx low for 4 ticks (16 clk) then high → START rejects at the mid sample, returns to IDLE, no rx_valid, no frame_err; next valid frame 0x41 received as 0x41.
4. Frame 0x5A with stop bit forced 0, line held low 3 bit periods, then frame 0x7A → exactly one frame_err pulse, rx_data keeps the prior value through the error, BREAK until high, then rx_data=0x7A with rx_valid.
5. rst_n driven low for 1 clk during data bit 3 of frame 0x33 → all outputs return to reset values, no strobe; after rst_n high, frame 0x42 received as 0x42.
6. sample_tick tied high (OVERSAMPLE clk per bit), frame 0xA5 → rx_data=0xA5, rx_valid once.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1-style serial receiver: 2-flop input synchronizer, mid-bit sampling driven by an
// oversampling tick, one-cycle valid / framing-error strobes.
module uart_rx #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam int unsigned IdxW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TickW-1:0] HalfLast = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] FullLast = TickW'(OVERSAMPLE - 1);
  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } state_e;

  state_e               state_q, state_d;
  logic                 rx_meta_q, rx_sync_q;
  logic [TickW-1:0]     tick_q, tick_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      tick_q    <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      tick_q    <= tick_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (sample_tick) begin
      case (state_q)
        StIdle: begin
          if (!rx_sync_q) begin
            state_d = StStart;
            tick_d  = '0;
          end
        end
        StStart: begin
          if (tick_q == HalfLast) begin
            // A start bit that is already high again at mid-bit was a glitch.
            if (!rx_sync_q) begin
              state_d = StData;
              tick_d  = '0;
              idx_d   = '0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        StData: begin
          if (tick_q == FullLast) begin
            shift_d = {rx_sync_q, shift_q[DATA_BITS-1:1]};
            tick_d  = '0;
            if (idx_q == IdxLast) begin
              state_d = StStop;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        StStop: begin
          if (tick_q == FullLast) begin
            if (rx_sync_q) begin
              data_d  = shift_q;
              valid_d = 1'b1;
              state_d = StIdle;
            end else begin
              err_d   = 1'b1;
              state_d = StBreak;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        StBreak: begin
          // Wait out a held-low line so it yields one error, not a stream of frames.
          if (rx_sync_q) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = err_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: clean frames, back-to-back, glitch, break, mid-frame reset,
// and a continuously asserted sample_tick.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sample_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int failures = 0;

  int  bit_clks = 64;
  bit  tick_always = 1'b0;
  int  div_cnt = 0;

  int         cyc = 0;
  int         valid_cnt = 0;
  int         err_cnt = 0;
  int         both_cnt = 0;
  int         long_cnt = 0;
  int         valid_cyc = 0;
  logic [7:0] last_data = 8'h00;
  logic       valid_prev = 1'b0;
  logic       err_prev = 1'b0;

  uart_rx #(
    .DATA_BITS (8),
    .OVERSAMPLE(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_tick(sample_tick),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Tick every 4th clk, or every clk when tied high; changes on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      div_cnt = (div_cnt + 1) % 4;
      sample_tick = tick_always || (div_cnt == 0);
    end
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rx_valid) begin
      valid_cnt <= valid_cnt + 1;
      last_data <= rx_data;
      valid_cyc <= cyc;
    end
    if (frame_err) err_cnt <= err_cnt + 1;
    if (rx_valid && frame_err) both_cnt <= both_cnt + 1;
    if ((rx_valid && valid_prev) || (frame_err && err_prev)) long_cnt <= long_cnt + 1;
    valid_prev <= rx_valid;
    err_prev   <= frame_err;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input int n);
    rx = b;
    wait_clks(n);
  endtask

  // Start + LSB-first data + one stop-bit period at the given level.
  task automatic send_frame(input logic [7:0] d, input logic stop_lvl, input string tag);
    send_bit(1'b0, bit_clks);
    check({tag, "_busy_in_frame"}, 32'(busy), 32'd1);
    for (int i = 0; i < 8; i++) send_bit(d[i], bit_clks);
    send_bit(stop_lvl, bit_clks);
  endtask

  int v0, e0, t0;

  initial begin
    // Reset state
    wait_clks(3);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    wait_clks(20);

    // 1: single frame 0x61, latency near 9.5 bit periods
    v0 = valid_cnt; e0 = err_cnt; t0 = cyc;
    send_frame(8'h61, 1'b1, "t1");
    check("t1_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check("t1_data", 32'(last_data), 32'h61);
    check("t1_rx_data_hold", 32'(rx_data), 32'h61);
    check("t1_no_err", 32'(err_cnt - e0), 32'd0);
    check("t1_busy_after", 32'(busy), 32'd0);
    check("t1_latency_ok", 32'((valid_cyc - t0 >= 605) && (valid_cyc - t0 <= 620)), 32'd1);
    wait_clks(40);

    // 2: back-to-back 0x00 then 0xFF, no idle gap
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'h00, 1'b1, "t2a");
    check("t2_first_data", 32'(last_data), 32'h00);
    send_frame(8'hFF, 1'b1, "t2b");
    check("t2_valid_cnt", 32'(valid_cnt - v0), 32'd2);
    check("t2_second_data", 32'(last_data), 32'hFF);
    check("t2_no_err", 32'(err_cnt - e0), 32'd0);
    wait_clks(40);

    // 3: 16-clk glitch rejected, then 0x41
    v0 = valid_cnt; e0 = err_cnt;
    send_bit(1'b0, 16);
    send_bit(1'b1, 100);
    check("t3_glitch_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("t3_glitch_no_err", 32'(err_cnt - e0), 32'd0);
    check("t3_glitch_idle", 32'(busy), 32'd0);
    send_frame(8'h41, 1'b1, "t3");
    check("t3_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check("t3_data", 32'(last_data), 32'h41);
    wait_clks(40);

    // 4: 0x5A with stop low, line low 3 bit periods, then 0x7A
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'h5A, 1'b0, "t4");
    send_bit(1'b0, 2 * bit_clks);
    check("t4_one_err", 32'(err_cnt - e0), 32'd1);
    check("t4_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("t4_data_kept", 32'(rx_data), 32'h41);
    check("t4_break_busy", 32'(busy), 32'd1);
    send_bit(1'b1, bit_clks);
    check("t4_idle_after_break", 32'(busy), 32'd0);
    send_frame(8'h7A, 1'b1, "t4b");
    check("t4_err_total", 32'(err_cnt - e0), 32'd1);
    check("t4_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check("t4_data", 32'(rx_data), 32'h7A);
    wait_clks(40);

    // 5: reset during data bit 3 of 0x33, then 0x42
    v0 = valid_cnt; e0 = err_cnt;
    send_bit(1'b0, bit_clks);
    send_bit(1'b1, bit_clks);
    send_bit(1'b1, bit_clks);
    send_bit(1'b0, bit_clks);
    send_bit(1'b0, bit_clks / 2);
    rst_n = 1'b0;
    wait_clks(1);
    rst_n = 1'b1;
    rx = 1'b1;
    check("t5_rst_data", 32'(rx_data), 32'h00);
    check("t5_rst_valid", 32'(rx_valid), 32'd0);
    check("t5_rst_err", 32'(frame_err), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    wait_clks(800);
    check("t5_no_strobe", 32'((valid_cnt - v0) + (err_cnt - e0)), 32'd0);
    send_frame(8'h42, 1'b1, "t5");
    check("t5_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check("t5_data", 32'(rx_data), 32'h42);
    wait_clks(40);

    // 6: sample_tick tied high, 16 clk per bit, 0xA5
    tick_always = 1'b1;
    bit_clks = 16;
    wait_clks(20);
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'hA5, 1'b1, "t6");
    wait_clks(20);
    check("t6_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check("t6_data", 32'(rx_data), 32'hA5);
    check("t6_no_err", 32'(err_cnt - e0), 32'd0);

    // Strobe properties over the whole run
    check("never_valid_and_err", 32'(both_cnt), 32'd0);
    check("strobes_single_cycle", 32'(long_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
